// File: rtl/rush3d_pkg.sv
// Shared raster-backend definitions: write-state encodings seen by the controller,
// pixel word field offsets and the default framebuffer base addresses.
package rush3d_pkg;

    typedef enum logic [3:0] {
        WRITE_STATE_WAIT       = 4'd0,
        WRITE_STATE_WRITE      = 4'd1,
        WRITE_STATE_PURGE      = 4'd2,
        WRITE_STATE_BACKGROUND = 4'd3
    } write_state_t;

    // Pixel FIFO word layout: {x[63:48], y[47:32], colour[31:0]}
    localparam int PIX_X_LSB      = 48;
    localparam int PIX_Y_LSB      = 32;
    localparam int PIX_COLOUR_LSB = 0;
    localparam int PIX_COORD_W    = 16;

    localparam logic [31:0] BUF0_BASE_DEFAULT = 32'h3000_0000;
    localparam logic [31:0] BUF1_BASE_DEFAULT = 32'h3012_C000;

endpackage

// File: rtl/rush3d_fb_addr_gen.sv
// Framebuffer byte address for pixel (x,y): base + (y*H_RES + x)*4, plus on-screen check.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module rush3d_fb_addr_gen
    import rush3d_pkg::*;
#(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic [31:0]            base,
    input  logic [PIX_COORD_W-1:0] x,
    input  logic [PIX_COORD_W-1:0] y,
    output logic [31:0]            address,
    output logic                   in_range
);

    localparam int IDX_W = $clog2(H_RES * V_RES);
    localparam int OFF_W = IDX_W + 2;

    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] offset;

    // Index is only meaningful when in_range; truncation for off-screen pixels is harmless.
    always_comb begin
        idx      = IDX_W'(y) * IDX_W'(H_RES) + IDX_W'(x);
        offset   = {idx, 2'b00};
        address  = base + {{(32-OFF_W){1'b0}}, offset};
        in_range = ({16'd0, x} < 32'(H_RES)) && ({16'd0, y} < 32'(V_RES));
    end

endmodule

// File: rtl/rush3d_framebuffer_writer.sv
// Final raster stage: pops shaded pixels into the back buffer and performs background fills.
// Latency: pop to avm_write one cycle; minimum two cycles per pixel, one cycle per fill word.
// Backpressure: avm_waitrequest stalls the write in place; FIFO popped only in WAIT.
module rush3d_framebuffer_writer
    import rush3d_pkg::*;
#(
    parameter int          H_RES     = 640,
    parameter int          V_RES     = 480,
    parameter logic [31:0] BUF0_BASE = BUF0_BASE_DEFAULT,
    parameter logic [31:0] BUF1_BASE = BUF1_BASE_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        fill_background_flag,
    input  logic        current_buffer_flag,
    input  logic [31:0] background_colour,
    input  logic [63:0] pixel_fifo_q,
    input  logic        pixel_fifo_empty,
    output logic        pixel_fifo_rdreq,
    output logic [31:0] avm_address,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    output logic [3:0]  framebuffer_write_state
);

    localparam int                NPIX     = H_RES * V_RES;
    localparam int                CNT_W    = $clog2(NPIX);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NPIX - 1);

    write_state_t     state, state_n;
    logic [CNT_W-1:0] fill_cnt, fill_cnt_n;
    logic [31:0]      addr_n, data_n;
    logic             write_n;
    logic [31:0]      back_base;
    logic [31:0]      pix_addr;
    logic             pix_in_range;

    // Only consumed on the WAIT exit cycle, so a mid-operation flip has no effect.
    assign back_base = current_buffer_flag ? BUF0_BASE : BUF1_BASE;

    rush3d_fb_addr_gen #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_addr_gen (
        .base     (back_base),
        .x        (pixel_fifo_q[PIX_X_LSB +: PIX_COORD_W]),
        .y        (pixel_fifo_q[PIX_Y_LSB +: PIX_COORD_W]),
        .address  (pix_addr),
        .in_range (pix_in_range)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= WRITE_STATE_WAIT;
            fill_cnt      <= '0;
            avm_address   <= '0;
            avm_writedata <= '0;
            avm_write     <= 1'b0;
        end else begin
            state         <= state_n;
            fill_cnt      <= fill_cnt_n;
            avm_address   <= addr_n;
            avm_writedata <= data_n;
            avm_write     <= write_n;
        end
    end

    always_comb begin
        state_n          = state;
        fill_cnt_n       = fill_cnt;
        addr_n           = avm_address;
        data_n           = avm_writedata;
        write_n          = avm_write;
        pixel_fifo_rdreq = 1'b0;
        case (state)
            WRITE_STATE_WAIT: begin
                // Fill request wins over a waiting pixel, which stays in the FIFO.
                if (fill_background_flag) begin
                    state_n    = WRITE_STATE_BACKGROUND;
                    fill_cnt_n = '0;
                    addr_n     = back_base;
                    data_n     = background_colour;
                    write_n    = 1'b1;
                end else if (!pixel_fifo_empty) begin
                    pixel_fifo_rdreq = 1'b1;
                    if (pix_in_range) begin
                        state_n = WRITE_STATE_WRITE;
                        addr_n  = pix_addr;
                        data_n  = pixel_fifo_q[PIX_COLOUR_LSB +: 32];
                        write_n = 1'b1;
                    end else begin
                        state_n = WRITE_STATE_PURGE;
                        write_n = 1'b0;
                    end
                end
            end
            WRITE_STATE_WRITE: begin
                if (!avm_waitrequest) begin
                    state_n = WRITE_STATE_WAIT;
                    write_n = 1'b0;
                end
            end
            WRITE_STATE_PURGE: begin
                state_n = WRITE_STATE_WAIT;
            end
            WRITE_STATE_BACKGROUND: begin
                if (avm_write && !avm_waitrequest) begin
                    if (fill_cnt == LAST_CNT) begin
                        state_n = WRITE_STATE_WAIT;
                        write_n = 1'b0;
                    end else begin
                        fill_cnt_n = fill_cnt + CNT_W'(1);
                        addr_n     = avm_address + 32'd4;
                    end
                end
            end
            default: begin
                state_n = WRITE_STATE_WAIT;
                write_n = 1'b0;
            end
        endcase
    end

    assign avm_byteenable          = 4'hF;
    assign framebuffer_write_state = state;

endmodule

// File: tb/tb_rush3d_framebuffer_writer.sv
// Directed bench: full-size instance for pixel writes and reset, 8x4 instance for fills.
// Accepted bus writes are matched against a scoreboard of expected {address, data}.
module tb_rush3d_framebuffer_writer;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    logic        b_fill = 0, b_cur = 0, b_empty = 1, b_wait = 0;
    logic [31:0] b_bg = '0;
    logic [63:0] b_q = '0;
    logic        b_rdreq, b_write;
    logic [31:0] b_addr, b_data;
    logic [3:0]  b_be, b_state;

    logic        s_fill = 0, s_cur = 0, s_empty = 1, s_wait = 0;
    logic [31:0] s_bg = '0;
    logic [63:0] s_q = '0;
    logic        s_rdreq, s_write;
    logic [31:0] s_addr, s_data;
    logic [3:0]  s_be, s_state;

    logic [63:0] b_fifo[$];
    logic [63:0] s_fifo[$];
    wr_t         b_exp[$];
    wr_t         s_exp[$];
    bit          b_pend = 0, s_pend = 0;

    int tests = 0;
    int fails = 0;
    int b_wr_cyc = 0, b_rd_cnt = 0, s_acc = 0, s_rd_cnt = 0;

    always #5 clock = ~clock;

    rush3d_framebuffer_writer dut_b (
        .clock                   (clock),
        .reset_n                 (reset_n),
        .fill_background_flag    (b_fill),
        .current_buffer_flag     (b_cur),
        .background_colour       (b_bg),
        .pixel_fifo_q            (b_q),
        .pixel_fifo_empty        (b_empty),
        .pixel_fifo_rdreq        (b_rdreq),
        .avm_address             (b_addr),
        .avm_write               (b_write),
        .avm_writedata           (b_data),
        .avm_byteenable          (b_be),
        .avm_waitrequest         (b_wait),
        .framebuffer_write_state (b_state)
    );

    rush3d_framebuffer_writer #(.H_RES(8), .V_RES(4)) dut_s (
        .clock                   (clock),
        .reset_n                 (reset_n),
        .fill_background_flag    (s_fill),
        .current_buffer_flag     (s_cur),
        .background_colour       (s_bg),
        .pixel_fifo_q            (s_q),
        .pixel_fifo_empty        (s_empty),
        .pixel_fifo_rdreq        (s_rdreq),
        .avm_address             (s_addr),
        .avm_write               (s_write),
        .avm_writedata           (s_data),
        .avm_byteenable          (s_be),
        .avm_waitrequest         (s_wait),
        .framebuffer_write_state (s_state)
    );

    function automatic logic [63:0] pix(input int x, input int y, input logic [31:0] c);
        return {16'(x), 16'(y), c};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input string tag, input logic [31:0] a, input logic [31:0] d,
                          inout wr_t q[$]);
        wr_t e;
        tests++;
        assert (q.size() != 0) else begin
            fails++;
            $error("FAIL %s unexpected write observed=%h/%h expected=none", tag, a, d);
        end
        if (q.size() != 0) begin
            e = q.pop_front();
            check({tag, "_addr"}, a, e.a);
            check({tag, "_data"}, d, e.d);
        end
    endtask

    // One cycle: at the falling edge retire pops from the last rising edge, present the
    // FIFO heads and waitrequests for the next rising edge, then observe the DUTs.
    task automatic step(input bit wb, input bit ws);
        @(negedge clock);
        if (b_pend) b_fifo.delete(0);
        if (s_pend) s_fifo.delete(0);
        b_empty = (b_fifo.size() == 0);
        b_q     = b_empty ? 64'd0 : b_fifo[0];
        s_empty = (s_fifo.size() == 0);
        s_q     = s_empty ? 64'd0 : s_fifo[0];
        b_wait  = wb;
        s_wait  = ws;
        #1;
        if (b_write) b_wr_cyc++;
        if (b_write && !b_wait) sb_pop("b_wr", b_addr, b_data, b_exp);
        if (s_write && !s_wait) begin
            s_acc++;
            sb_pop("s_wr", s_addr, s_data, s_exp);
        end
        b_pend = b_rdreq;
        s_pend = s_rdreq;
        if (b_rdreq) b_rd_cnt++;
        if (s_rdreq) s_rd_cnt++;
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) step(0, 0);
        check("rst_state", b_state, 0);
        check("rst_write", b_write, 0);
        check("rst_addr", b_addr, 0);
        check("rst_data", b_data, 0);
        check("rst_be", b_be, 4'hF);
        check("rst_s_state", s_state, 0);
        check("rst_s_be", s_be, 4'hF);
        reset_n = 1;
        step(0, 0);

        // Single pixel to BUF1, no stall
        b_cur = 0; b_rd_cnt = 0; b_wr_cyc = 0;
        b_fifo.push_back(pix(3, 2, 32'h00FF00FF));
        b_exp.push_back('{32'h3012D40C, 32'h00FF00FF});
        step(0, 0);
        check("p1_rdreq", b_rdreq, 1);
        check("p1_state_wait", b_state, 0);
        step(0, 0);
        check("p1_state_write", b_state, 1);
        check("p1_write", b_write, 1);
        check("p1_rdreq_off", b_rdreq, 0);
        step(0, 0);
        check("p1_state_back", b_state, 0);
        check("p1_write_off", b_write, 0);
        check("p1_rd_pulses", b_rd_cnt, 1);
        check("p1_wr_cycles", b_wr_cyc, 1);

        // Same pixel to BUF0, stalled five cycles; flag flip mid-write must not move address
        b_cur = 1; b_rd_cnt = 0; b_wr_cyc = 0;
        b_fifo.push_back(pix(3, 2, 32'h00FF00FF));
        b_exp.push_back('{32'h3000140C, 32'h00FF00FF});
        step(0, 0);
        check("p2_rdreq", b_rdreq, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 0);
            if (i == 0) b_cur = 0;
            check("p2_stall_state", b_state, 1);
            check("p2_stall_write", b_write, 1);
            check("p2_stall_addr", b_addr, 32'h3000140C);
            check("p2_stall_data", b_data, 32'h00FF00FF);
        end
        step(0, 0);
        check("p2_accept_write", b_write, 1);
        step(0, 0);
        check("p2_state_back", b_state, 0);
        check("p2_wr_cycles", b_wr_cyc, 6);
        check("p2_rd_pulses", b_rd_cnt, 1);

        // Off-screen pixel purged, following pixel written
        b_cur = 0; b_rd_cnt = 0; b_wr_cyc = 0;
        b_fifo.push_back(pix(640, 0, 32'hDEADBEEF));
        b_fifo.push_back(pix(1, 1, 32'hAABBCCDD));
        b_exp.push_back('{32'h3012CA04, 32'hAABBCCDD});
        step(0, 0);
        check("p3_rdreq", b_rdreq, 1);
        step(0, 0);
        check("p3_state_purge", b_state, 2);
        check("p3_purge_write", b_write, 0);
        check("p3_purge_rdreq", b_rdreq, 0);
        step(0, 0);
        check("p3_state_wait", b_state, 0);
        check("p3_rdreq2", b_rdreq, 1);
        step(0, 0);
        check("p3_state_write", b_state, 1);
        step(0, 0);
        check("p3_state_back", b_state, 0);
        check("p3_wr_cycles", b_wr_cyc, 1);
        check("p3_rd_pulses", b_rd_cnt, 2);

        // Background fill on 8x4, random stalls, flag dropped after two cycles
        s_bg = 32'hFF102030; s_cur = 0; s_acc = 0;
        for (int i = 0; i < 32; i++) s_exp.push_back('{32'h3012C000 + 32'(i * 4), 32'hFF102030});
        s_fill = 1;
        step(0, 0);
        check("f1_state_start", s_state, 3);
        step(0, 1);
        step(0, 0);
        s_fill = 0;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            if (s_state != 4'd3) break;
            n++;
            step(0, 1'($urandom_range(0, 1)));
        end
        check("f1_state_done", s_state, 0);
        check("f1_write_off", s_write, 0);
        check("f1_accepted", s_acc, 32);
        check("f1_sb_left", s_exp.size(), 0);
        step(0, 0);
        check("f1_stays_wait", s_state, 0);

        // Fill and pixel together: fill first, pixel only afterwards
        s_acc = 0; s_rd_cnt = 0;
        for (int i = 0; i < 32; i++) s_exp.push_back('{32'h3012C000 + 32'(i * 4), 32'hFF102030});
        s_exp.push_back('{32'h3012C028, 32'h11223344});
        s_fifo.push_back(pix(2, 1, 32'h11223344));
        s_fill = 1;
        step(0, 0);
        check("f2_no_rdreq", s_rdreq, 0);
        step(0, 0);
        check("f2_state_bg", s_state, 3);
        s_fill = 0;
        for (int i = 0; i < 100; i++) begin
            if (s_state != 4'd3) break;
            step(0, 0);
        end
        check("f2_rd_during_fill", s_rd_cnt, 1);
        check("f2_rdreq_after", s_rdreq, 1);
        check("f2_fill_acc", s_acc, 32);
        step(0, 0);
        check("f2_pix_state", s_state, 1);
        step(0, 0);
        check("f2_back_wait", s_state, 0);
        check("f2_sb_left", s_exp.size(), 0);

        // Reset during a stalled write
        b_cur = 0;
        b_fifo.push_back(pix(5, 5, 32'h12345678));
        step(1, 0);
        step(1, 0);
        check("r_state_write", b_state, 1);
        step(1, 0);
        reset_n = 0;
        step(1, 0);
        check("r_state", b_state, 0);
        check("r_write", b_write, 0);
        reset_n = 1;
        b_rd_cnt = 0;
        b_fifo.push_back(pix(0, 0, 32'hCAFEF00D));
        b_exp.push_back('{32'h3012C000, 32'hCAFEF00D});
        step(0, 0);
        check("r_rdreq", b_rdreq, 1);
        step(0, 0);
        check("r_state_write2", b_state, 1);
        step(0, 0);
        check("r_state_back", b_state, 0);
        check("r_b_sb_left", b_exp.size(), 0);
        check("r_rd_pulses", b_rd_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
